// File: rtl/xc_malu_pkg.sv
// Shared definitions for the MALU long-arithmetic slice: sequencer state
// encodings, default multiply step count and step counter width.
package xc_malu_pkg;

    localparam int MDR_STEPS_DEF = 32;
    localparam int COUNT_W       = 6;

    // One-hot so each phase strobe is a single state bit.
    typedef enum logic [6:0] {
        ST_INIT   = 7'b000_0001,
        ST_MDR    = 7'b000_0010,
        ST_MSUB_1 = 7'b000_0100,
        ST_MACC_1 = 7'b000_1000,
        ST_MMUL_2 = 7'b001_0000,
        ST_MMUL_1 = 7'b010_0000,
        ST_DONE   = 7'b100_0000
    } seq_state_t;

    function automatic logic uop_is_onehot(input logic [3:0] uop);
        return (uop != 4'd0) && ((uop & (uop - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/xc_malu_long_seq.sv
// Sequencer for the MALU long-arithmetic slice: steps madd/msub/macc/mmul
// through their phases and owns the accumulator, carry and step counter.
module xc_malu_long_seq
    import xc_malu_pkg::*;
#(
    parameter int MDR_STEPS = MDR_STEPS_DEF
) (
    input  logic                 g_clk,
    input  logic                 g_reset,
    input  logic                 valid,
    input  logic                 flush,
    input  logic                 uop_madd,
    input  logic                 uop_msub,
    input  logic                 uop_macc,
    input  logic                 uop_mmul,
    input  logic [63:0]          n_acc,
    input  logic                 n_carry,
    input  logic                 slice_ready,
    input  logic [63:0]          slice_result,
    input  logic [63:0]          mdr_n_acc,
    input  logic                 mdr_n_carry,
    output logic                 fsm_init,
    output logic                 fsm_mdr,
    output logic                 fsm_msub_1,
    output logic                 fsm_macc_1,
    output logic                 fsm_mmul_1,
    output logic                 fsm_mmul_2,
    output logic                 fsm_done,
    output logic [63:0]          acc,
    output logic                 carry,
    output logic [COUNT_W-1:0]   count,
    output logic                 ready,
    output logic [63:0]          result
);

    localparam logic [COUNT_W-1:0] LAST_STEP = COUNT_W'(MDR_STEPS - 1);

    seq_state_t state;
    logic [3:0] uop_vec;
    logic       op_ok;
    logic       madd_go;

    // Malformed selects (zero or several uop bits) are treated as no request.
    assign uop_vec = {uop_mmul, uop_macc, uop_msub, uop_madd};
    assign op_ok   = valid && uop_is_onehot(uop_vec);
    assign madd_go = op_ok && uop_madd && (state == ST_INIT);

    assign fsm_init   = (state == ST_INIT);
    assign fsm_mdr    = (state == ST_MDR);
    assign fsm_msub_1 = (state == ST_MSUB_1);
    assign fsm_macc_1 = (state == ST_MACC_1);
    assign fsm_mmul_2 = (state == ST_MMUL_2);
    assign fsm_mmul_1 = (state == ST_MMUL_1);
    assign fsm_done   = (state == ST_DONE);

    // NOTE: ready/result are combinational so a madd completes in its issue
    // cycle; every other completion comes straight out of the DONE state.
    assign ready  = !flush && (fsm_done || (madd_go && slice_ready));
    assign result = fsm_done ? acc : (madd_go ? slice_result : 64'd0);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state <= ST_INIT;
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
        end else if (flush) begin
            state <= ST_INIT;
            count <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (op_ok) begin
                        if (uop_mmul) begin
                            acc   <= '0;
                            carry <= 1'b0;
                            count <= '0;
                            state <= ST_MDR;
                        end else begin
                            acc   <= n_acc;
                            carry <= n_carry;
                            if (uop_msub)      state <= ST_MSUB_1;
                            else if (uop_macc) state <= ST_MACC_1;
                        end
                    end
                end
                ST_MDR: begin
                    acc   <= mdr_n_acc;
                    carry <= mdr_n_carry;
                    if (count == LAST_STEP) begin
                        count <= '0;
                        state <= ST_MMUL_2;
                    end else begin
                        count <= count + COUNT_W'(1);
                    end
                end
                ST_MMUL_2: begin
                    acc   <= n_acc;
                    carry <= n_carry;
                    state <= ST_MMUL_1;
                end
                ST_MSUB_1, ST_MACC_1, ST_MMUL_1: begin
                    acc   <= n_acc;
                    carry <= n_carry;
                    state <= ST_DONE;
                end
                ST_DONE: state <= ST_INIT;
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_xc_malu_long_seq.sv
// Self-checking bench for xc_malu_long_seq: scoreboarded results plus
// phase, latency, flush, reset and malformed-request checks.
module tb_xc_malu_long_seq;

    localparam logic [6:0] S_INIT   = 7'h01;
    localparam logic [6:0] S_MDR    = 7'h02;
    localparam logic [6:0] S_MSUB_1 = 7'h04;
    localparam logic [6:0] S_MACC_1 = 7'h08;
    localparam logic [6:0] S_MMUL_2 = 7'h10;
    localparam logic [6:0] S_DONE   = 7'h40;

    logic        g_clk = 1'b0;
    logic        g_reset, valid, flush;
    logic        uop_madd, uop_msub, uop_macc, uop_mmul;
    logic [63:0] n_acc, slice_result, mdr_n_acc;
    logic        n_carry, slice_ready, mdr_n_carry;
    logic        fsm_init, fsm_mdr, fsm_msub_1, fsm_macc_1, fsm_mmul_1, fsm_mmul_2, fsm_done;
    logic [63:0] acc, result;
    logic        carry, ready;
    logic [5:0]  count;
    logic [6:0]  strobes;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_q[$];
    logic        env_on;
    logic [63:0] env_add;
    logic        env_carry;

    xc_malu_long_seq dut (
        .g_clk(g_clk), .g_reset(g_reset), .valid(valid), .flush(flush),
        .uop_madd(uop_madd), .uop_msub(uop_msub), .uop_macc(uop_macc), .uop_mmul(uop_mmul),
        .n_acc(n_acc), .n_carry(n_carry), .slice_ready(slice_ready), .slice_result(slice_result),
        .mdr_n_acc(mdr_n_acc), .mdr_n_carry(mdr_n_carry),
        .fsm_init(fsm_init), .fsm_mdr(fsm_mdr), .fsm_msub_1(fsm_msub_1), .fsm_macc_1(fsm_macc_1),
        .fsm_mmul_1(fsm_mmul_1), .fsm_mmul_2(fsm_mmul_2), .fsm_done(fsm_done),
        .acc(acc), .carry(carry), .count(count), .ready(ready), .result(result)
    );

    assign strobes = {fsm_done, fsm_mmul_1, fsm_mmul_2, fsm_macc_1, fsm_msub_1, fsm_mdr, fsm_init};

    always #5 g_clk = ~g_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Environment stand-in for the long slice and multiply-step datapath.
    task automatic apply_env();
        if (env_on) begin
            n_acc       = acc + env_add;
            n_carry     = env_carry;
            mdr_n_acc   = acc + 64'd1;
            mdr_n_carry = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
        apply_env();
    endtask

    task automatic set_uop(input logic [3:0] u);
        {uop_mmul, uop_macc, uop_msub, uop_madd} = u;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int c;
        c = 0;
        while (ready !== 1'b1 && c < 100) begin
            tick();
            c++;
        end
        check(tag, 64'(c), 64'(exp_lat));
    endtask

    // Scoreboard: every completion must match the oldest outstanding result.
    always @(negedge g_clk) begin
        if (ready === 1'b1) begin
            if (exp_q.size() == 0) check("spurious_ready", 64'(ready), 64'd0);
            else check("result", result, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c;
        logic [63:0] snap;

        g_reset = 1'b1; valid = 1'b0; flush = 1'b0; set_uop(4'b0000);
        n_acc = '0; n_carry = 1'b0; slice_ready = 1'b0; slice_result = '0;
        mdr_n_acc = '0; mdr_n_carry = 1'b0;
        env_on = 1'b0; env_add = '0; env_carry = 1'b0;
        repeat (2) @(posedge g_clk);
        #1;
        check("rst_state", 64'(strobes), 64'(S_INIT));
        check("rst_acc", acc, 64'd0);
        check("rst_carry", 64'(carry), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_result", result, 64'd0);
        g_reset = 1'b0;
        tick();

        // madd: same-cycle completion, back-to-back issue
        valid = 1'b1; set_uop(4'b0001); slice_ready = 1'b1;
        slice_result = 64'h1_0000_0000; n_acc = 64'h0000_1234_5678_9abc; n_carry = 1'b1;
        exp_q.push_back(64'h1_0000_0000);
        #1;
        check("madd_ready", 64'(ready), 64'd1);
        check("madd_result", result, 64'h1_0000_0000);
        tick();
        check("madd_state", 64'(strobes), 64'(S_INIT));
        check("madd_acc", acc, 64'h0000_1234_5678_9abc);
        check("madd_carry", 64'(carry), 64'd1);
        slice_ready = 1'b0; slice_result = 64'hdead; n_acc = 64'hffff_ffff_ffff_ffff; n_carry = 1'b0;
        #1;
        check("madd_slice_busy", 64'(ready), 64'd0);
        tick();
        check("madd2_acc", acc, 64'hffff_ffff_ffff_ffff);
        check("madd2_carry", 64'(carry), 64'd0);
        slice_ready = 1'b1; slice_result = 64'h0123_4567_89ab_cdef; n_acc = 64'h42;
        exp_q.push_back(64'h0123_4567_89ab_cdef);
        tick();
        check("madd3_acc", acc, 64'h42);
        valid = 1'b0; set_uop(4'b0000); slice_ready = 1'b0;

        // msub: INIT -> MSUB_1 -> DONE
        valid = 1'b1; set_uop(4'b0010); n_acc = 64'h1_FFFF_FFFF; n_carry = 1'b1;
        exp_q.push_back(64'h1_FFFF_FFFE);
        #1;
        check("msub_init", 64'(strobes), 64'(S_INIT));
        check("msub_init_ready", 64'(ready), 64'd0);
        tick();
        check("msub_s1", 64'(strobes), 64'(S_MSUB_1));
        check("msub_s1_acc", acc, 64'h1_FFFF_FFFF);
        check("msub_s1_carry", 64'(carry), 64'd1);
        n_acc = 64'h1_FFFF_FFFE; n_carry = 1'b0;
        tick();
        check("msub_done", 64'(strobes), 64'(S_DONE));
        check("msub_ready", 64'(ready), 64'd1);
        valid = 1'b0; set_uop(4'b0000);
        tick();
        check("msub_back_init", 64'(strobes), 64'(S_INIT));
        check("msub_acc_hold", acc, 64'h1_FFFF_FFFE);

        // mmul: 32 MDR steps of +1, then two +5 accumulate phases
        env_on = 1'b1; env_add = 64'd5; env_carry = 1'b0; apply_env();
        valid = 1'b1; set_uop(4'b1000);
        exp_q.push_back(64'd42);
        c = 0;
        while (ready !== 1'b1 && c < 100) begin
            tick();
            c++;
            if (c <= 32) check("mdr_count", 64'(count), 64'(c - 1));
            if (c == 33) begin
                check("mmul2_state", 64'(strobes), 64'(S_MMUL_2));
                check("mdr_acc", acc, 64'd32);
            end
        end
        check("mmul_latency", 64'(c), 64'd35);
        valid = 1'b0; set_uop(4'b0000);
        tick();
        check("mmul_back_init", 64'(strobes), 64'(S_INIT));

        // flush in MDR at count 10
        valid = 1'b1; set_uop(4'b1000);
        c = 0;
        while (count != 6'd10 && c < 50) begin
            tick();
            c++;
        end
        check("flush_reach", 64'(count), 64'd10);
        check("flush_in_mdr", 64'(strobes), 64'(S_MDR));
        snap = acc;
        flush = 1'b1;
        #1;
        check("flush_ready", 64'(ready), 64'd0);
        tick();
        flush = 1'b0; valid = 1'b0; set_uop(4'b0000);
        check("flush_state", 64'(strobes), 64'(S_INIT));
        check("flush_count", 64'(count), 64'd0);
        check("flush_acc_hold", acc, snap);

        // macc after flush completes normally
        env_carry = 1'b1; apply_env();
        valid = 1'b1; set_uop(4'b0100);
        exp_q.push_back(snap + 64'd10);
        wait_done("macc_latency", 2);
        check("macc_carry", 64'(carry), 64'd1);
        valid = 1'b0; set_uop(4'b0000);
        tick();

        // flush while in DONE suppresses ready
        valid = 1'b1; set_uop(4'b0100);
        tick();
        tick();
        check("fd_state", 64'(strobes), 64'(S_DONE));
        flush = 1'b1;
        #1;
        check("fd_ready", 64'(ready), 64'd0);
        valid = 1'b0; set_uop(4'b0000);
        tick();
        flush = 1'b0;
        check("fd_back_init", 64'(strobes), 64'(S_INIT));

        // async reset mid-MACC_1
        valid = 1'b1; set_uop(4'b0100);
        tick();
        check("rm_state", 64'(strobes), 64'(S_MACC_1));
        check("rm_carry_pre", 64'(carry), 64'd1);
        #1 g_reset = 1'b1;
        #1;
        check("rm_init", 64'(strobes), 64'(S_INIT));
        check("rm_acc", acc, 64'd0);
        check("rm_carry", 64'(carry), 64'd0);
        check("rm_ready", 64'(ready), 64'd0);
        valid = 1'b0; set_uop(4'b0000); g_reset = 1'b0;
        tick();
        check("rm_stay_init", 64'(strobes), 64'(S_INIT));

        // malformed requests: two uop bits, then none
        env_on = 1'b0; n_acc = 64'hbad; n_carry = 1'b1;
        valid = 1'b1; set_uop(4'b0110);
        #1;
        check("multi_ready", 64'(ready), 64'd0);
        tick();
        check("multi_state", 64'(strobes), 64'(S_INIT));
        check("multi_acc", acc, 64'd0);
        set_uop(4'b0000);
        tick();
        check("none_state", 64'(strobes), 64'(S_INIT));
        check("none_acc", acc, 64'd0);
        check("none_carry", 64'(carry), 64'd0);
        valid = 1'b0;
        tick();

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
